// File: rtl/fbs_pkg.sv
// Shared types and constants for the function backup system sequencer.
package fbs_pkg;

    localparam int FBS_CW        = 16;
    localparam int FBS_DEPTH_DEF = 16;
    localparam int FBS_LAT_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_SAVE_DONE,
        ST_REST,
        ST_REST_WAIT,
        ST_REST_LOAD
    } fbs_seq_state_t;

    // Value loaded into the wait timer so REST_WAIT lasts exactly rd_lat cycles.
    function automatic logic [FBS_LAT_W-1:0] fbs_wait_load(input int rd_lat);
        return (rd_lat > 0) ? FBS_LAT_W'(rd_lat - 1) : '0;
    endfunction

endpackage

// File: rtl/fbs_lat_timer.sv
// Loadable 3-bit down-counter that times the stack read latency during REST_WAIT.
module fbs_lat_timer
    import fbs_pkg::*;
#(
    parameter int W = FBS_LAT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/fbs_sequencer.sv
// Function backup system sequencer: call/return handshake, backup/restore strobes, error flags.
// Optional FBS_SEQ_PERF_EN adds max_depth and ops_cnt statistics outputs.
module fbs_sequencer
    import fbs_pkg::*;
#(
    parameter int DEPTH  = FBS_DEPTH_DEF,
    parameter int RD_LAT = 1,
    parameter int CW     = FBS_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          call_req,
    input  logic          ret_req,
    output logic          call_ack,
    output logic          ret_ack,
    output logic          regs_load,
    output logic          fbs_backup,
    output logic          fbs_restore,
    input  logic [CW-1:0] fcc_in,
    output logic [CW-1:0] depth,
    output logic          busy,
    output logic          err_overflow,
    output logic          err_underflow,
    output logic          err_fcc,
    input  logic          err_clr
`ifdef FBS_SEQ_PERF_EN
    ,
    output logic [CW-1:0] max_depth,
    output logic [31:0]   ops_cnt
`endif
);

    fbs_seq_state_t r_state;
    fbs_seq_state_t w_state_next;

    logic [CW-1:0] r_depth;
    logic [CW-1:0] w_depth_next;
    logic          r_call_ack;
    logic          r_ret_ack;
    logic          r_regs_load;
    logic          r_backup;
    logic          r_restore;
    logic          r_busy;
    logic          r_err_ovf;
    logic          r_err_udf;
    logic          r_err_fcc;
    logic          r_fcc_arm;

    logic          w_sample;
    logic          w_ovf_evt;
    logic          w_udf_evt;
    logic          w_fcc_evt;
    logic          w_timer_load;
    logic          w_timer_done;
    logic          w_call_ack_next;
    logic          w_ret_ack_next;
    logic          w_regs_load_next;
    logic          w_backup_next;
    logic          w_restore_next;
    logic          w_busy_next;

    // Requests are never taken while an ack from the previous operation is visible.
    assign w_sample  = (r_state == ST_IDLE) && !r_call_ack && !r_ret_ack;
    assign w_fcc_evt = (r_state == ST_IDLE) && r_fcc_arm && (fcc_in != r_depth);

    fbs_lat_timer #(
        .W (FBS_LAT_W)
    ) u_lat_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_timer_load),
        .i_load_val (fbs_wait_load(RD_LAT)),
        .o_done     (w_timer_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_depth_next = r_depth;
        w_ovf_evt    = 1'b0;
        w_udf_evt    = 1'b0;
        w_timer_load = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_sample) begin
                    if (call_req) begin
                        if (r_depth < CW'(DEPTH)) begin
                            w_state_next = ST_SAVE;
                        end else begin
                            w_ovf_evt = 1'b1;
                        end
                    end else if (ret_req) begin
                        if (r_depth != '0) begin
                            w_state_next = ST_REST;
                        end else begin
                            w_udf_evt = 1'b1;
                        end
                    end
                end
            end
            ST_SAVE: begin
                w_depth_next = r_depth + CW'(1);
                w_state_next = ST_SAVE_DONE;
            end
            ST_SAVE_DONE: begin
                w_state_next = ST_IDLE;
            end
            ST_REST: begin
                w_depth_next = r_depth - CW'(1);
                if (RD_LAT == 0) begin
                    w_state_next = ST_REST_LOAD;
                end else begin
                    w_timer_load = 1'b1;
                    w_state_next = ST_REST_WAIT;
                end
            end
            ST_REST_WAIT: begin
                if (w_timer_done) begin
                    w_state_next = ST_REST_LOAD;
                end
            end
            ST_REST_LOAD: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered.
        w_call_ack_next  = (w_state_next == ST_SAVE_DONE) || w_ovf_evt;
        w_ret_ack_next   = (w_state_next == ST_REST_LOAD) || w_udf_evt;
        w_regs_load_next = (w_state_next == ST_REST_LOAD);
        w_backup_next    = (w_state_next == ST_SAVE);
        w_restore_next   = (w_state_next == ST_REST);
        w_busy_next      = (w_state_next != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth     <= '0;
            r_call_ack  <= 1'b0;
            r_ret_ack   <= 1'b0;
            r_regs_load <= 1'b0;
            r_backup    <= 1'b0;
            r_restore   <= 1'b0;
            r_busy      <= 1'b0;
            r_fcc_arm   <= 1'b0;
        end else begin
            r_depth     <= w_depth_next;
            r_call_ack  <= w_call_ack_next;
            r_ret_ack   <= w_ret_ack_next;
            r_regs_load <= w_regs_load_next;
            r_backup    <= w_backup_next;
            r_restore   <= w_restore_next;
            r_busy      <= w_busy_next;
            r_fcc_arm   <= 1'b1;
        end
    end

    // Sticky flags: a new error event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
            r_err_fcc <= 1'b0;
        end else begin
            r_err_ovf <= w_ovf_evt | (r_err_ovf & ~err_clr);
            r_err_udf <= w_udf_evt | (r_err_udf & ~err_clr);
            r_err_fcc <= w_fcc_evt | (r_err_fcc & ~err_clr);
        end
    end

    assign call_ack      = r_call_ack;
    assign ret_ack       = r_ret_ack;
    assign regs_load     = r_regs_load;
    assign fbs_backup    = r_backup;
    assign fbs_restore   = r_restore;
    assign depth         = r_depth;
    assign busy          = r_busy;
    assign err_overflow  = r_err_ovf;
    assign err_underflow = r_err_udf;
    assign err_fcc       = r_err_fcc;

`ifdef FBS_SEQ_PERF_EN
    logic [CW-1:0] r_max_depth;
    logic [31:0]   r_ops_cnt;
    logic          w_op_done;

    assign w_op_done = (r_state == ST_SAVE_DONE) || (r_state == ST_REST_LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_depth <= '0;
            r_ops_cnt   <= '0;
        end else if (err_clr) begin
            r_max_depth <= '0;
            r_ops_cnt   <= '0;
        end else begin
            if (r_depth > r_max_depth) begin
                r_max_depth <= r_depth;
            end
            if (w_op_done) begin
                r_ops_cnt <= r_ops_cnt + 32'd1;
            end
        end
    end

    assign max_depth = r_max_depth;
    assign ops_cnt   = r_ops_cnt;
`endif

endmodule

// File: tb/tb_fbs_sequencer.sv
// Self-checking bench for fbs_sequencer: directed steps plus random call/return traffic
// checked cycle by cycle against a latency/depth model of the controller.
module tb_fbs_sequencer;

    localparam int DEPTH_T  = 4;
    localparam int RD_LAT_T = 2;
    localparam int CW_T     = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            call_req;
    logic            ret_req;
    logic            call_ack;
    logic            ret_ack;
    logic            regs_load;
    logic            fbs_backup;
    logic            fbs_restore;
    logic [CW_T-1:0] fcc_in;
    logic [CW_T-1:0] depth;
    logic            busy;
    logic            err_overflow;
    logic            err_underflow;
    logic            err_fcc;
    logic            err_clr;
`ifdef FBS_SEQ_PERF_EN
    logic [CW_T-1:0] max_depth;
    logic [31:0]     ops_cnt;
`endif

    fbs_sequencer #(
        .DEPTH  (DEPTH_T),
        .RD_LAT (RD_LAT_T),
        .CW     (CW_T)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .call_req      (call_req),
        .ret_req       (ret_req),
        .call_ack      (call_ack),
        .ret_ack       (ret_ack),
        .regs_load     (regs_load),
        .fbs_backup    (fbs_backup),
        .fbs_restore   (fbs_restore),
        .fcc_in        (fcc_in),
        .depth         (depth),
        .busy          (busy),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_fcc       (err_fcc),
        .err_clr       (err_clr)
`ifdef FBS_SEQ_PERF_EN
        ,
        .max_depth     (max_depth),
        .ops_cnt       (ops_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Backup stack model: its FCC follows the strobes the controller issues.
    logic [CW_T-1:0] stk;
    logic            fcc_force;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)           stk <= '0;
        else if (fbs_backup)  stk <= stk + 16'd1;
        else if (fbs_restore) stk <= stk - 16'd1;
    end
    assign fcc_in = fcc_force ? 16'd5 : stk;

    int n_total  = 0;
    int n_passed = 0;
    int depth_m  = 0;
    int ops_m    = 0;
    int max_m    = 0;
    bit e_ovf    = 0;
    bit e_udf    = 0;
    bit e_fcc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, ".err_overflow"},  32'(err_overflow),  32'(e_ovf));
        chk({tag, ".err_underflow"}, 32'(err_underflow), 32'(e_udf));
        chk({tag, ".err_fcc"},       32'(err_fcc),       32'(e_fcc));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".call_ack"},    32'(call_ack),    32'd0);
        chk({tag, ".ret_ack"},     32'(ret_ack),     32'd0);
        chk({tag, ".regs_load"},   32'(regs_load),   32'd0);
        chk({tag, ".fbs_backup"},  32'(fbs_backup),  32'd0);
        chk({tag, ".fbs_restore"}, 32'(fbs_restore), 32'd0);
        chk({tag, ".busy"},        32'(busy),        32'd0);
    endtask

    // One call or return; req held for 'hold' cycles after the sampling edge.
    task automatic op(input bit is_call, input int hold);
        bit    ok;
        int    lat;
        int    d0;
        int    exp_d;
        string nm;
        d0  = depth_m;
        ok  = is_call ? (d0 < DEPTH_T) : (d0 > 0);
        lat = !ok ? 1 : (is_call ? 2 : RD_LAT_T + 2);
        nm  = is_call ? "call" : "ret";
        if (hold > lat) hold = lat;
        if (hold < 1)   hold = 1;
        if (is_call) call_req = 1'b1;
        else         ret_req  = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            if (k == hold) begin
                call_req = 1'b0;
                ret_req  = 1'b0;
            end
            if (!ok && k == 1) begin
                if (is_call) e_ovf = 1'b1;
                else         e_udf = 1'b1;
            end
            exp_d = (ok && k >= 2) ? (is_call ? d0 + 1 : d0 - 1) : d0;
            chk({nm, ".fbs_backup"},  32'(fbs_backup),  32'(is_call && ok && k == 1));
            chk({nm, ".fbs_restore"}, 32'(fbs_restore), 32'(!is_call && ok && k == 1));
            chk({nm, ".call_ack"},    32'(call_ack),    32'(is_call && k == lat));
            chk({nm, ".ret_ack"},     32'(ret_ack),     32'(!is_call && k == lat));
            chk({nm, ".regs_load"},   32'(regs_load),   32'(!is_call && ok && k == lat));
            chk({nm, ".busy"},        32'(busy),        32'(ok));
            chk({nm, ".depth"},       32'(depth),       32'(exp_d));
            chk_flags(nm);
        end
        if (ok) begin
            depth_m = is_call ? d0 + 1 : d0 - 1;
            ops_m++;
            if (depth_m > max_m) max_m = depth_m;
        end
        @(posedge clk); #1;
        chk_quiet({nm, ".gap"});
        $display("op %-4s ok=%0d hold=%0d depth %0d->%0d", nm, ok, hold, d0, depth_m);
    endtask

    task automatic clr();
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        e_ovf = 1'b0;
        e_udf = 1'b0;
        e_fcc = 1'b0;
        ops_m = 0;
        max_m = depth_m;
        chk_flags("clr");
        $display("err_clr depth=%0d", depth_m);
    endtask

    initial begin
        int t_ret;
        int exp_d;
        rst_n     = 1'b0;
        call_req  = 1'b0;
        ret_req   = 1'b0;
        err_clr   = 1'b0;
        fcc_force = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_quiet("rst");
        chk("rst.depth", 32'(depth), 32'd0);
        chk_flags("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_quiet("rst_rel");
        chk_flags("rst_rel");
        $display("reset released");

        // Single call, then three calls/returns
        op(1'b1, 1);
        op(1'b1, 2);
        op(1'b1, 1);
        op(1'b0, 1);
        op(1'b0, 3);
        op(1'b0, 4);

        // Underflow then clear
        op(1'b0, 1);
        clr();

        // Overflow at DEPTH
        for (int i = 0; i < 5; i++) op(1'b1, 1);
        chk("ovf.depth", 32'(depth), 32'(DEPTH_T));
        clr();
        for (int i = 0; i < 3; i++) op(1'b0, 2);

        // Simultaneous call and return at depth 1: call first
        t_ret = 3 + RD_LAT_T + 2;
        call_req = 1'b1;
        ret_req  = 1'b1;
        for (int k = 1; k <= t_ret; k++) begin
            @(posedge clk); #1;
            if (k == 1) call_req = 1'b0;
            if (k == 4) ret_req  = 1'b0;
            exp_d = (k < 2) ? depth_m : (k < 5) ? depth_m + 1 : depth_m;
            chk("both.fbs_backup",  32'(fbs_backup),  32'(k == 1));
            chk("both.call_ack",    32'(call_ack),    32'(k == 2));
            chk("both.fbs_restore", 32'(fbs_restore), 32'(k == 4));
            chk("both.ret_ack",     32'(ret_ack),     32'(k == t_ret));
            chk("both.regs_load",   32'(regs_load),   32'(k == t_ret));
            chk("both.depth",       32'(depth),       32'(exp_d));
        end
        ops_m += 2;
        if (depth_m + 1 > max_m) max_m = depth_m + 1;
        @(posedge clk); #1;
        chk_quiet("both.gap");
        chk_flags("both");
        $display("simultaneous call+ret done depth=%0d", depth_m);

        // FCC mismatch in IDLE
        while (depth_m > 0) op(1'b0, 1);
        fcc_force = 1'b1;
        @(posedge clk); #1;
        fcc_force = 1'b0;
        e_fcc = 1'b1;
        chk_flags("fcc");
        $display("fcc forced to 5 at depth 0");
        clr();

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            op(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)));
            if ($urandom_range(0, 7) == 0) clr();
        end

`ifdef FBS_SEQ_PERF_EN
        chk("perf.ops_cnt",   ops_cnt,          32'(ops_m));
        chk("perf.max_depth", 32'(max_depth),   32'(max_m));
`endif

        // Reset asserted during REST_WAIT
        if (depth_m == 0) op(1'b1, 1);
        ret_req = 1'b1;
        @(posedge clk); #1;
        chk("rstw.fbs_restore", 32'(fbs_restore), 32'd1);
        @(posedge clk); #1;
        chk("rstw.busy", 32'(busy), 32'd1);
        rst_n   = 1'b0;
        ret_req = 1'b0;
        #1;
        chk_quiet("rstw.in_reset");
        chk("rstw.depth", 32'(depth), 32'd0);
        @(posedge clk); #2;
        rst_n   = 1'b1;
        depth_m = 0;
        e_ovf   = 1'b0;
        e_udf   = 1'b0;
        e_fcc   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk_quiet("rstw.after");
            chk("rstw.after.depth", 32'(depth), 32'd0);
            chk_flags("rstw.after");
        end
        $display("reset during REST_WAIT done");

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/fbs_sequencer.md
Name: fbs_sequencer

Overview:
- Controller that sequences the function backup system on behalf of the core.
- Accepts call (save register file) and return (restore register file) requests through a req/ack handshake.
- Issues single-cycle backup/restore strobes to the backup stack and waits out the cache read latency.
- Flags overflow, underflow and FCC mismatch; tracks its own nesting depth.

Parameters:
- DEPTH, 16, maximum number of nested backups; a call at DEPTH is refused.
- RD_LAT, 1, cycles between the restore strobe and restored data valid on the stack's dataOut (0..7).
- CW, 16, width of depth and FCC values.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- call_req  in  1  core requests a backup; level, held until call_ack.
- ret_req  in  1  core requests a restore; level, held until ret_ack.
- call_ack  out  1  one-cycle pulse: backup committed.
- ret_ack  out  1  one-cycle pulse: restored data valid this cycle.
- regs_load  out  1  register-file load enable for restored data; asserted together with ret_ack.
- fbs_backup  out  1  backup strobe to the stack.
- fbs_restore  out  1  restore strobe to the stack.
- fcc_in  in  CW  current FCC from the stack.
- depth  out  CW  controller's nesting count.
- busy  out  1  high in every state except IDLE.
- err_overflow  out  1  sticky error flag.
- err_underflow  out  1  sticky error flag.
- err_fcc  out  1  sticky error flag.
- err_clr  in  1  synchronous clear of all three sticky error flags.

Behaviour:
- Reset: all outputs are registered and reset to 0; depth = 0; state = IDLE.
- States: IDLE, SAVE, SAVE_DONE, REST, REST_WAIT, REST_LOAD.
- IDLE, call_req=1, depth<DEPTH: go to SAVE.
- IDLE, call_req=1, depth==DEPTH: set err_overflow; pulse call_ack next cycle with no strobe issued; stay in IDLE.
- IDLE, ret_req=1 (call_req=0), depth>0: go to REST.
- IDLE, ret_req=1 (call_req=0), depth==0: set err_underflow; pulse ret_ack without regs_load; no strobe issued.
- Simultaneous call_req and ret_req in IDLE: call wins; ret_req stays pending and is served after the call completes.
- SAVE: fbs_backup=1 for exactly one cycle; depth increments at the end of the cycle. Go to SAVE_DONE.
- SAVE_DONE: call_ack=1; return to IDLE. Call latency is 2 cycles from request sample to ack.
- REST: fbs_restore=1 for exactly one cycle; depth decrements.
- REST: if RD_LAT==0, go directly to REST_LOAD; otherwise go to REST_WAIT.
- REST_WAIT: an internal counter runs RD_LAT-1 down to 0, then goes to REST_LOAD.
- REST_LOAD: regs_load=1 and ret_ack=1 for one cycle; return to IDLE. Restore latency is RD_LAT+2 cycles.
- Request dropped before ack: the operation still completes and the ack still pulses; the core ignores it.
- A new request is never sampled in the same cycle as an ack. The request is re-sampled in IDLE one cycle after the ack, so a held req produces back-to-back operations.
- FCC check: in IDLE, if fcc_in != depth (after reset, FCC is not reset in the stack), set err_fcc. The check is suppressed for the first cycle after leaving reset.
- err_clr: clears the three flags in the cycle it is high. If an error event occurs in the same cycle, the set wins.
- Reset asserted mid-operation: returns immediately to IDLE with all strobes low. A partially issued strobe is never repeated.
- depth never wraps; it saturates between 0 and DEPTH by construction.

Optional Feature:
- Macro FBS_SEQ_PERF_EN.
- When defined: adds output max_depth [CW-1:0], the high-water mark of depth, and output ops_cnt [31:0], counting completed successful saves plus restores. Both reset to 0 and are cleared by err_clr. ops_cnt wraps at 2^32.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared package fbs_pkg:
  - state encoding typedef fbs_seq_state_t;
  - constant FBS_CW = 16;
  - constant FBS_DEPTH_DEF = 16.
- One sub-module, fbs_lat_timer: a loadable down-counter for REST_WAIT, with load and done signals, width 3.
- The remainder is a single FSM.

Test Plan:
- Reset then call_req held for 1 cycle and released: fbs_backup high in cycle 1, call_ack in cycle 2, depth=1, no errors.
- Three calls then three returns with RD_LAT=2: each ret_ack and regs_load arrive 4 cycles after ret_req is sampled; depth goes 3→0; fbs_restore pulses exactly 3 times.
- Return with depth=0: err_underflow=1, ret_ack pulses, regs_load=0, no fbs_restore; err_clr clears the flag next cycle.
- DEPTH=4, five calls: the fifth gives err_overflow=1 with no fbs_backup; depth stays 4.
- call_req and ret_req both high with depth=1: call served first (depth 2), then restore (depth 1); two acks in order.
- fcc_in forced to 5 while depth=0 in IDLE: err_fcc=1. Separately, rst_n low during REST_WAIT: state IDLE, all outputs 0, no regs_load.
